stream_traffic_endpoint: RTL



---
 rtl/stream_endpoint_pkg.sv | 19 +
 rtl/stream_endpoint_checker.sv | 79 +++++++
 rtl/stream_traffic_endpoint.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/stream_endpoint_pkg.sv
// Shared types and helpers for the stream traffic endpoint.
package stream_endpoint_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CNT_W = 16;

  // Word at position idx of a run starting from seed; callers truncate to
  // their data width, which gives the modulo-2^W wrap.
  function automatic logic [31:0] expected_word(input logic [31:0] seed,
                                                input logic [31:0] idx);
    return seed + idx;
  endfunction

endpackage

// File: rtl/stream_endpoint_checker.sv
// Receive side of the endpoint: rx_ready with periodic stalls, comparison
// of each received word against the transmitted value plus one, and the
// received / mismatch counters.
module stream_endpoint_checker
  import stream_endpoint_pkg::*;
#(
  parameter int W            = 16,
  parameter int SEED         = 0,
  parameter int STALL_PERIOD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_run,
  input  logic             i_run_next,
  input  logic [W-1:0]     i_rx_data,
  input  logic             i_rx_valid,
  output logic             o_rx_ready,
  output logic             o_beat,
  output logic             o_mismatch,
  output logic [CNT_W-1:0] o_rx_count,
  output logic [CNT_W-1:0] o_err_count
);

  localparam bit              STALL_EN   = (STALL_PERIOD > 0);
  localparam logic [CNT_W-1:0] STALL_LAST = STALL_EN ? CNT_W'(STALL_PERIOD - 1) : '0;

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] w_stall_next;
  logic             r_rx_ready;
  logic [CNT_W-1:0] r_rx_count;
  logic [CNT_W-1:0] r_err_count;
  logic [W-1:0]     w_expected;

  // Position of the next cycle within the stall period.
  always_comb begin
    w_stall_next = r_stall_cnt;
    if (i_clear)
      w_stall_next = '0;
    else if (i_run)
      w_stall_next = (r_stall_cnt == STALL_LAST) ? '0 : r_stall_cnt + CNT_W'(1);
  end

  // rx_ready is registered: it looks ahead at the next state and stall slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_rx_ready  <= 1'b0;
    end else begin
      r_stall_cnt <= w_stall_next;
      r_rx_ready  <= i_run_next && !(STALL_EN && (w_stall_next == STALL_LAST));
    end
  end

  assign w_expected = W'(expected_word(32'(SEED), {16'd0, r_rx_count} + 32'd1));
  assign o_beat     = i_rx_valid && r_rx_ready;
  assign o_mismatch = o_beat && (i_rx_data != w_expected);

  // Received-word and saturating mismatch counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_count  <= '0;
      r_err_count <= '0;
    end else if (i_clear) begin
      r_rx_count  <= '0;
      r_err_count <= '0;
    end else begin
      if (o_beat)
        r_rx_count <= r_rx_count + CNT_W'(1);
      if (o_mismatch && (r_err_count != {CNT_W{1'b1}}))
        r_err_count <= r_err_count + CNT_W'(1);
    end
  end

  assign o_rx_ready  = r_rx_ready;
  assign o_rx_count  = r_rx_count;
  assign o_err_count = r_err_count;

endmodule

// File: rtl/stream_traffic_endpoint.sv
// Traffic endpoint: sends an incrementing word sequence into a stream stage
// and checks the stage output for value + 1. Holds the run FSM, the
// transmit side and the no-progress timeout.
module stream_traffic_endpoint
  import stream_endpoint_pkg::*;
#(
  parameter int EXAMPLE_WIDTH = 15,
  parameter int SEED          = 0,
  parameter int STALL_PERIOD  = 4,
  parameter int TIMEOUT       = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [15:0]          num_words,
  output logic [EXAMPLE_WIDTH:0] tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [EXAMPLE_WIDTH:0] rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [15:0]          err_count,
  output logic [15:0]          rx_count
);

  localparam int               W       = EXAMPLE_WIDTH + 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_error;
  logic             r_tx_valid;
  logic [W-1:0]     r_tx_data;
  logic [CNT_W-1:0] r_tx_count;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_to;

  logic             w_start_acc;
  logic             w_run;
  logic             w_run_next;
  logic             w_tx_beat;
  logic             w_rx_beat;
  logic             w_mismatch;
  logic             w_last;
  logic             w_to_fire;
  logic [CNT_W-1:0] w_rx_count;
  logic [CNT_W-1:0] w_err_count;

  assign w_run       = (r_state == RUN);
  assign w_start_acc = start && !w_run;
  assign w_tx_beat   = r_tx_valid && tx_ready;
  assign w_last      = w_run && w_rx_beat && ((w_rx_count + CNT_W'(1)) == r_count);
  assign w_to_fire   = w_run && !w_rx_beat && (r_to == TO_LAST);
  assign w_run_next  = (w_start_acc && (num_words != '0)) || (w_run && !w_last && !w_to_fire);

  // Run FSM with transmit side, timeout and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= W'(SEED);
      r_tx_count <= '0;
      r_count    <= '0;
      r_to       <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_count    <= num_words;
            r_tx_count <= '0;
            r_to       <= '0;
            r_error    <= 1'b0;
            r_tx_data  <= W'(SEED);
            if (num_words == '0) begin
              r_state    <= DONE;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_tx_valid <= 1'b0;
            end else begin
              r_state    <= RUN;
              r_busy     <= 1'b1;
              r_done     <= 1'b0;
              r_tx_valid <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_tx_beat) begin
            r_tx_count <= r_tx_count + CNT_W'(1);
            r_tx_data  <= r_tx_data + W'(1);
            r_tx_valid <= (r_tx_count + CNT_W'(1)) < r_count;
          end
          r_to    <= w_rx_beat ? '0 : r_to + CNT_W'(1);
          r_error <= r_error || w_mismatch || w_to_fire;
          if (w_last || w_to_fire) begin
            r_state    <= DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_tx_valid <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_tx_valid <= 1'b0;
        end
      endcase
    end
  end

  stream_endpoint_checker #(
    .W            (W),
    .SEED         (SEED),
    .STALL_PERIOD (STALL_PERIOD)
  ) u_checker (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_start_acc),
    .i_run       (w_run),
    .i_run_next  (w_run_next),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .o_rx_ready  (rx_ready),
    .o_beat      (w_rx_beat),
    .o_mismatch  (w_mismatch),
    .o_rx_count  (w_rx_count),
    .o_err_count (w_err_count)
  );

  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign err_count = w_err_count;
  assign rx_count  = w_rx_count;

endmodule
